// File: rtl/umem_pkg.sv
// Shared types and defaults for the memory-access bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package umem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Failure cause of the last access; only "none vs. other" reaches a port today,
    // the individual codes are kept for a future status register.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_CONFLICT = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_cause_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 200;

endpackage

// File: rtl/umem_timeout_counter.sv
// Saturating wait-state counter with an expire flag at TIMEOUT_CYCLES-1.
// Latency: count updates one cycle after enable; expire is combinational from the count.
// Backpressure: none; clear has priority over enable, count never wraps.
module umem_timeout_counter
    import umem_pkg::*;
#(
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {TIMEOUT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/umem_bridge.sv
// Memory-access stage: turns RD/WR strobes into a req/ready memory transaction and a one-cycle ACK.
// Latency: ACK 2 cycles after the strobe is sampled with zero-wait memory, +1 per wait state; 1 cycle for rejected accesses.
// Backpressure: memory stalls via Ready=0 up to TIMEOUT_CYCLES, then the access is aborted with Error.
module umem_bridge
    import umem_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_ADDR = 32,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      UMEMBRIDGE_CLOCK_50,
    input  logic                      UMEMBRIDGE_ResetInLow_In,
    input  logic                      UMEMBRIDGE_RD_In,
    input  logic                      UMEMBRIDGE_WR_In,
    input  logic [DATAWIDTH_ADDR-1:0] UMEMBRIDGE_Address_InBus,
    input  logic [DATAWIDTH_BUS-1:0]  UMEMBRIDGE_WriteData_InBus,
    output logic                      UMEMBRIDGE_ACK_Out,
    output logic [DATAWIDTH_BUS-1:0]  UMEMBRIDGE_ReadData_OutBus,
    output logic                      UMEMBRIDGE_Error_Out,
    output logic                      UMEMBRIDGE_MemReq_Out,
    output logic                      UMEMBRIDGE_MemWE_Out,
    output logic [DATAWIDTH_ADDR-1:0] UMEMBRIDGE_MemAddr_OutBus,
    output logic [DATAWIDTH_BUS-1:0]  UMEMBRIDGE_MemWData_OutBus,
    input  logic [DATAWIDTH_BUS-1:0]  UMEMBRIDGE_MemRData_InBus,
    input  logic                      UMEMBRIDGE_MemReady_In
);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_start;
    logic                      w_finish;
    err_cause_t                w_cause;
    err_cause_t                r_cause;
    logic                      w_expire;
    logic                      r_req;
    logic                      r_we;
    logic [DATAWIDTH_ADDR-1:0] r_addr;
    logic [DATAWIDTH_BUS-1:0]  r_wdata;
    logic [DATAWIDTH_BUS-1:0]  r_rdata;

    umem_timeout_counter #(
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (UMEMBRIDGE_CLOCK_50),
        .i_rst_n  (UMEMBRIDGE_ResetInLow_In),
        .i_clear  (r_state != ST_WAIT),
        .i_enable (r_state == ST_WAIT),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge UMEMBRIDGE_CLOCK_50 or negedge UMEMBRIDGE_ResetInLow_In) begin
        if (!UMEMBRIDGE_ResetInLow_In) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, plus start/finish strobes and the failure cause of the access being closed.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_cause      = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if ((UMEMBRIDGE_RD_In ^ UMEMBRIDGE_WR_In) && (UMEMBRIDGE_Address_InBus[1:0] == 2'b00)) begin
                    w_next_state = ST_WAIT;
                    w_start      = 1'b1;
                end else if (UMEMBRIDGE_RD_In && UMEMBRIDGE_WR_In) begin
                    w_next_state = ST_DONE;
                    w_finish     = 1'b1;
                    w_cause      = ERR_CONFLICT;
                end else if (UMEMBRIDGE_RD_In || UMEMBRIDGE_WR_In) begin
                    w_next_state = ST_DONE;
                    w_finish     = 1'b1;
                    w_cause      = ERR_MISALIGN;
                end
            end
            ST_WAIT: begin
                // Ready beats a simultaneous timeout.
                if (UMEMBRIDGE_MemReady_In) begin
                    w_next_state = ST_DONE;
                    w_finish     = 1'b1;
                end else if (w_expire) begin
                    w_next_state = ST_DONE;
                    w_finish     = 1'b1;
                    w_cause      = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Memory-side request registers, captured read data and the pending failure cause.
    always_ff @(posedge UMEMBRIDGE_CLOCK_50 or negedge UMEMBRIDGE_ResetInLow_In) begin
        if (!UMEMBRIDGE_ResetInLow_In) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cause <= ERR_NONE;
        end else begin
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= UMEMBRIDGE_WR_In;
                r_addr  <= {2'b00, UMEMBRIDGE_Address_InBus[DATAWIDTH_ADDR-1:2]};
                r_wdata <= UMEMBRIDGE_WriteData_InBus;
            end
            if ((r_state == ST_WAIT) && w_finish) begin
                r_req <= 1'b0;
                if (UMEMBRIDGE_MemReady_In && !r_we) begin
                    r_rdata <= UMEMBRIDGE_MemRData_InBus;
                end
            end
            if (w_finish) begin
                r_cause <= w_cause;
            end
        end
    end

    assign UMEMBRIDGE_ACK_Out         = (r_state == ST_DONE);
    assign UMEMBRIDGE_Error_Out       = (r_state == ST_DONE) && (r_cause != ERR_NONE);
    assign UMEMBRIDGE_ReadData_OutBus = r_rdata;
    assign UMEMBRIDGE_MemReq_Out      = r_req;
    assign UMEMBRIDGE_MemWE_Out       = r_we;
    assign UMEMBRIDGE_MemAddr_OutBus  = r_addr;
    assign UMEMBRIDGE_MemWData_OutBus = r_wdata;

endmodule

// File: tb/tb_umem_bridge.sv
// Self-checking bench for umem_bridge: directed scenarios followed by random accesses.
// Latency: expectations derived per access from wait count and access legality.
// Backpressure: memory Ready is driven by the bench after a chosen number of wait states.
module tb_umem_bridge;

    localparam int TO = 200;

    logic        clk;
    logic        rst_n;
    logic        i_rd;
    logic        i_wr;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_memaddr;
    logic [31:0] o_memwdata;
    logic [31:0] i_memrdata;
    logic        i_ready;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rdata = '0;

    umem_bridge #(
        .DATAWIDTH_BUS  (32),
        .DATAWIDTH_ADDR (32),
        .TIMEOUT_WIDTH  (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .UMEMBRIDGE_CLOCK_50        (clk),
        .UMEMBRIDGE_ResetInLow_In   (rst_n),
        .UMEMBRIDGE_RD_In           (i_rd),
        .UMEMBRIDGE_WR_In           (i_wr),
        .UMEMBRIDGE_Address_InBus   (i_addr),
        .UMEMBRIDGE_WriteData_InBus (i_wdata),
        .UMEMBRIDGE_ACK_Out         (o_ack),
        .UMEMBRIDGE_ReadData_OutBus (o_rdata),
        .UMEMBRIDGE_Error_Out       (o_err),
        .UMEMBRIDGE_MemReq_Out      (o_req),
        .UMEMBRIDGE_MemWE_Out       (o_we),
        .UMEMBRIDGE_MemAddr_OutBus  (o_memaddr),
        .UMEMBRIDGE_MemWData_OutBus (o_memwdata),
        .UMEMBRIDGE_MemRData_InBus  (i_memrdata),
        .UMEMBRIDGE_MemReady_In     (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One control-unit access; called at a falling edge while the bridge is idle.
    // wait_n = number of wait states before Ready (>= TO means memory never answers in time).
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_n,
                          input logic [31:0] rdat, input logic drop);
        int          lat_exp;
        int          reqc_exp;
        logic        err_exp;
        int          k;
        int          lat;
        int          reqc;
        logic        err_obs;
        logic        ok;
        logic [31:0] rd_before;

        // Reference expectations straight from the access rules.
        if ((rd && wr) || (addr[1:0] != 2'b00)) begin
            lat_exp = 1; reqc_exp = 0; err_exp = 1'b1;
        end else if (wait_n < TO) begin
            lat_exp = wait_n + 2; reqc_exp = wait_n + 1; err_exp = 1'b0;
        end else begin
            lat_exp = TO + 1; reqc_exp = TO; err_exp = 1'b1;
        end
        rd_before = exp_rdata;
        if (!err_exp && rd) exp_rdata = rdat;

        i_rd = rd; i_wr = wr; i_addr = addr; i_wdata = wd;
        i_ready = 1'b0; i_memrdata = $urandom;
        k = 0; lat = 0; reqc = 0; ok = 1'b1; err_obs = 1'b0;
        while (lat == 0 && k < TO + 50) begin
            @(negedge clk);
            k++;
            if (o_req) begin
                reqc++;
                if (o_we !== wr || o_memaddr !== (addr >> 2) || o_memwdata !== wd) ok = 1'b0;
            end
            if (o_ack) begin
                lat = k;
                err_obs = o_err;
            end else if (o_err !== 1'b0 || o_rdata !== rd_before) begin
                ok = 1'b0;
            end
            if (drop && k == 1) begin
                i_rd = 1'b0; i_wr = 1'b0; i_addr = $urandom; i_wdata = $urandom;
            end
            i_ready    = (k == wait_n + 1);
            i_memrdata = i_ready ? rdat : $urandom;
        end
        chk("ack_latency", lat, lat_exp);
        chk("req_cycles", reqc, reqc_exp);
        chk("error_flag", {31'b0, err_obs}, {31'b0, err_exp});
        chk("hold_stable", {31'b0, ok}, 32'd1);
        i_rd = 1'b0; i_wr = 1'b0; i_ready = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", {31'b0, o_ack}, 32'd0);
        chk("read_data", o_rdata, exp_rdata);
    endtask

    initial begin
        int          acks;
        int          kind;
        logic [31:0] a;
        int          w;

        rst_n = 1'b1;
        i_rd = 1'b0; i_wr = 1'b0; i_addr = '0; i_wdata = '0;
        i_memrdata = '0; i_ready = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, o_ack}, 32'd0);
        chk("rst_err", {31'b0, o_err}, 32'd0);
        chk("rst_req", {31'b0, o_req}, 32'd0);
        chk("rst_we", {31'b0, o_we}, 32'd0);
        chk("rst_memaddr", o_memaddr, 32'd0);
        chk("rst_memwdata", o_memwdata, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 0, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5, 32'hCAFE_0000, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0013, 32'h1111_1111, 0, 32'h2222_2222, 1'b0);
        access(1'b1, 1'b1, 32'h0000_0000, 32'h3333_3333, 0, 32'h4444_4444, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h5555_5555, 1000, 32'h6666_6666, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h7777_7777, TO - 1, 32'h8888_8888, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0048, 32'h9999_9999, 3, 32'hAAAA_AAAA, 1'b1);

        // Reset in the middle of a read's wait states.
        i_rd = 1'b1; i_addr = 32'h0000_0100; i_wdata = 32'h0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_req", {31'b0, o_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_req", {31'b0, o_req}, 32'd0);
        chk("mid_reset_ack", {31'b0, o_ack}, 32'd0);
        exp_rdata = '0;
        chk("mid_reset_rdata", o_rdata, exp_rdata);
        @(negedge clk);
        i_rd = 1'b0;
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_ack) acks++;
        end
        chk("no_ack_after_reset", acks, 0);
        access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1, 32'h0F0F_A5A5, 1'b0);

        // Random accesses, back to back.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            else if (a[1:0] == 2'b00) a[0] = 1'b1;
            if ($urandom_range(0, 15) == 0) w = $urandom_range(TO - 3, TO + 3);
            else w = $urandom_range(0, 6);
            access(kind != 1, kind != 0, a, $urandom, w, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
